// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing, RGB field layout and shared types for the
// VGA sync generator.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    // Two bits per colour channel, packed {R1,R0,G1,G0,B1,B0}
    localparam int RGB_R_LSB = 4;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_LSB = 0;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } sync_flags_t;

    function automatic int line_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int sync_first(input int visible, input int front);
        return visible + front;
    endfunction

    function automatic int sync_last(input int visible, input int front, input int sync);
        return visible + front + sync - 1;
    endfunction

    function automatic logic [5:0] rgb_pack(input logic [1:0] r, input logic [1:0] g,
                                            input logic [1:0] b);
        logic [5:0] p;
        p = '0;
        p[RGB_R_LSB +: 2] = r;
        p[RGB_G_LSB +: 2] = g;
        p[RGB_B_LSB +: 2] = b;
        return p;
    endfunction

    localparam logic [5:0] FG_RGB_DEF = rgb_pack(2'b11, 2'b11, 2'b11);
    localparam logic [5:0] BG_RGB_DEF = rgb_pack(2'b00, 2'b00, 2'b00);

endpackage

// File: rtl/vga_sync_gen_delay.sv
// Width x depth shift register used to hold decoded sync flags until the
// frame buffer colour for the same pixel arrives. Depth 0 is a passthrough.
module sync_delay_line #(
    parameter int               WIDTH       = 3,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stages [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stages[i] <= RESET_VALUE;
                end
            end else begin
                stages[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign dout = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster counters, sync decode and registered pixel output stage; flags are
// delayed to meet the frame buffer's colour result for the same pixel.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int         H_VISIBLE       = H_VISIBLE_DEF,
    parameter int         H_FRONT         = H_FRONT_DEF,
    parameter int         H_SYNC          = H_SYNC_DEF,
    parameter int         H_BACK          = H_BACK_DEF,
    parameter int         V_VISIBLE       = V_VISIBLE_DEF,
    parameter int         V_FRONT         = V_FRONT_DEF,
    parameter int         V_SYNC          = V_SYNC_DEF,
    parameter int         V_BACK          = V_BACK_DEF,
    parameter bit         SYNC_ACTIVE_LOW = 1'b1,
    parameter int         PIPE_LATENCY    = 1,
    parameter logic [5:0] FG_RGB          = FG_RGB_DEF,
    parameter logic [5:0] BG_RGB          = BG_RGB_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] counter_H,
    output logic [9:0] counter_V,
    input  logic       colour_in,
    output logic [5:0] rgb_out,
    output logic       hsync,
    output logic       vsync,
    output logic       video_active,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(sync_first(H_VISIBLE, H_FRONT));
    localparam logic [9:0] HS_LAST  = 10'(sync_last(H_VISIBLE, H_FRONT, H_SYNC));
    localparam logic [9:0] VS_FIRST = 10'(sync_first(V_VISIBLE, V_FRONT));
    localparam logic [9:0] VS_LAST  = 10'(sync_last(V_VISIBLE, V_FRONT, V_SYNC));

    sync_flags_t raw_flags;
    sync_flags_t dly_flags;

    // The H and V wraps coincide at the last pixel of the frame, which is
    // the only place frame_count advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_H   <= '0;
            counter_V   <= '0;
            frame_count <= '0;
        end else if (counter_H == H_LAST) begin
            counter_H <= '0;
            if (counter_V == V_LAST) begin
                counter_V   <= '0;
                frame_count <= frame_count + 8'd1;
            end else begin
                counter_V <= counter_V + 10'd1;
            end
        end else begin
            counter_H <= counter_H + 10'd1;
        end
    end

    assign frame_start = (counter_H == 10'd0) && (counter_V == 10'd0);

    always_comb begin
        raw_flags        = '0;
        raw_flags.active = (counter_H < H_VIS) && (counter_V < V_VIS);
        raw_flags.hs     = (counter_H >= HS_FIRST) && (counter_H <= HS_LAST);
        raw_flags.vs     = (counter_V >= VS_FIRST) && (counter_V <= VS_LAST);
    end

    sync_delay_line #(
        .WIDTH       ($bits(sync_flags_t)),
        .DEPTH       (PIPE_LATENCY),
        .RESET_VALUE ('0)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (raw_flags),
        .dout  (dly_flags)
    );

    // Blanking forces black regardless of what the frame buffer returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out      <= '0;
            hsync        <= SYNC_ACTIVE_LOW;
            vsync        <= SYNC_ACTIVE_LOW;
            video_active <= 1'b0;
        end else begin
            rgb_out      <= dly_flags.active ? (colour_in ? FG_RGB : BG_RGB) : 6'b000000;
            hsync        <= dly_flags.hs ^ SYNC_ACTIVE_LOW;
            vsync        <= dly_flags.vs ^ SYNC_ACTIVE_LOW;
            video_active <= dly_flags.active;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: two full-timing instances (latency 1 and 2)
// and one shrunken-raster instance for frame-level behaviour.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [5:0] rgb;
        logic       hsync;
        logic       vsync;
        logic       act;
    } exp_t;

    localparam exp_t IDLE = '{rgb: 6'd0, hsync: 1'b1, vsync: 1'b1, act: 1'b0};

    logic clk = 1'b0;
    logic rst_n;
    logic colour_a, colour_b, colour_c;

    logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
    logic [5:0] a_rgb, b_rgb, c_rgb;
    logic       a_hs, a_vs, a_act, a_fs;
    logic       b_hs, b_vs, b_act, b_fs;
    logic       c_hs, c_vs, c_act, c_fs;
    logic [7:0] a_fc, b_fc, c_fc;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc = 0;
    int mh, mv, sh, sv, sframes;
    int d1h, d1v, d2h, d2v;
    int a_hs_first, a_hs_len, c_vs_first, c_vs_len;
    bit running = 1'b0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    vga_sync_gen #(.PIPE_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .counter_H(a_h), .counter_V(a_v),
        .colour_in(colour_a), .rgb_out(a_rgb), .hsync(a_hs), .vsync(a_vs),
        .video_active(a_act), .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_sync_gen #(.PIPE_LATENCY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .counter_H(b_h), .counter_V(b_v),
        .colour_in(colour_b), .rgb_out(b_rgb), .hsync(b_hs), .vsync(b_vs),
        .video_active(b_act), .frame_start(b_fs), .frame_count(b_fc)
    );

    // 15-pixel lines, 10-line frames so frame wrap and vsync fit a short run
    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIPE_LATENCY(1)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .counter_H(c_h), .counter_V(c_v),
        .colour_in(colour_c), .rgb_out(c_rgb), .hsync(c_hs), .vsync(c_vs),
        .video_active(c_act), .frame_start(c_fs), .frame_count(c_fc)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s (cycle %0d): actual %0d, required %0d",
                      name, cyc, actual, expected);
    endtask

    function automatic exp_t make_exp(input int h, input int v, input int hv, input int hf,
                                      input int hsw, input int vv, input int vf,
                                      input int vsw, input logic colour);
        exp_t e;
        logic act;
        act     = (h < hv) && (v < vv);
        e.act   = act;
        e.rgb   = act ? (colour ? 6'h3F : 6'h00) : 6'h00;
        e.hsync = !((h >= hv + hf) && (h < hv + hf + hsw));
        e.vsync = !((v >= vv + vf) && (v < vv + vf + vsw));
        return e;
    endfunction

    // Checkerboard from bit 3 of each counter; blanking returns 1 on purpose
    function automatic logic checker_colour(input int h, input int v);
        return ((((h >> 3) ^ (v >> 3)) & 1) == 1) || !((h < 640) && (v < 480));
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_a_H"}, int'(a_h), 0);
        checkOutput({tag, "_a_V"}, int'(a_v), 0);
        checkOutput({tag, "_a_rgb"}, int'(a_rgb), 0);
        checkOutput({tag, "_a_hsync"}, int'(a_hs), 1);
        checkOutput({tag, "_a_vsync"}, int'(a_vs), 1);
        checkOutput({tag, "_a_active"}, int'(a_act), 0);
        checkOutput({tag, "_a_fstart"}, int'(a_fs), 1);
        checkOutput({tag, "_a_fcount"}, int'(a_fc), 0);
        checkOutput({tag, "_b_H"}, int'(b_h), 0);
        checkOutput({tag, "_b_V"}, int'(b_v), 0);
        checkOutput({tag, "_b_rgb"}, int'(b_rgb), 0);
        checkOutput({tag, "_b_hsync"}, int'(b_hs), 1);
        checkOutput({tag, "_b_vsync"}, int'(b_vs), 1);
        checkOutput({tag, "_b_active"}, int'(b_act), 0);
        checkOutput({tag, "_b_fstart"}, int'(b_fs), 1);
        checkOutput({tag, "_b_fcount"}, int'(b_fc), 0);
        checkOutput({tag, "_c_H"}, int'(c_h), 0);
        checkOutput({tag, "_c_V"}, int'(c_v), 0);
        checkOutput({tag, "_c_rgb"}, int'(c_rgb), 0);
        checkOutput({tag, "_c_hsync"}, int'(c_hs), 1);
        checkOutput({tag, "_c_vsync"}, int'(c_vs), 1);
        checkOutput({tag, "_c_active"}, int'(c_act), 0);
        checkOutput({tag, "_c_fstart"}, int'(c_fs), 1);
        checkOutput({tag, "_c_fcount"}, int'(c_fc), 0);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc = 0; mh = 0; mv = 0; sh = 0; sv = 0; sframes = 0;
        d1h = 0; d1v = 0; d2h = 0; d2v = 0;
        a_hs_first = -1; a_hs_len = 0; c_vs_first = -1; c_vs_len = 0;
        q_a.delete(); q_b.delete(); q_c.delete();
        repeat (2) q_a.push_back(IDLE);
        repeat (3) q_b.push_back(IDLE);
        repeat (2) q_c.push_back(IDLE);
        running = 1'b1;
    endtask

    // One iteration per pixel clock: check counters, queue expected outputs,
    // drive the frame buffer colour that corresponds to dut_b's delayed pixel.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checkOutput("a_counter_H", int'(a_h), mh);
            checkOutput("a_counter_V", int'(a_v), mv);
            checkOutput("a_frame_start", int'(a_fs), int'(mh == 0 && mv == 0));
            checkOutput("b_counter_H", int'(b_h), mh);
            checkOutput("b_counter_V", int'(b_v), mv);
            checkOutput("c_counter_H", int'(c_h), sh);
            checkOutput("c_counter_V", int'(c_v), sv);
            checkOutput("c_frame_start", int'(c_fs), int'(sh == 0 && sv == 0));
            checkOutput("c_frame_count", int'(c_fc), sframes % 256);

            q_a.push_back(make_exp(mh, mv, 640, 16, 96, 480, 10, 2, 1'b1));
            q_b.push_back(make_exp(mh, mv, 640, 16, 96, 480, 10, 2, checker_colour(mh, mv)));
            q_c.push_back(make_exp(sh, sv, 8, 2, 3, 6, 1, 2, 1'b0));

            colour_b = checker_colour(d2h, d2v);
            d2h = d1h; d2v = d1v;
            d1h = mh;  d1v = mv;

            if (cyc < 800 && a_hs == 1'b0) begin
                if (a_hs_first < 0) a_hs_first = cyc;
                a_hs_len++;
            end
            if (cyc < 150 && c_vs == 1'b0) begin
                if (c_vs_first < 0) c_vs_first = cyc;
                c_vs_len++;
            end

            cyc++;
            mh++;
            if (mh == 800) begin
                mh = 0;
                mv++;
                if (mv == 525) mv = 0;
            end
            sh++;
            if (sh == 15) begin
                sh = 0;
                sv++;
                if (sv == 10) begin
                    sv = 0;
                    sframes++;
                end
            end
        end
    endtask

    // Monitor: every running cycle the DUTs present one pixel; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (running) begin
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    checkOutput("a_rgb", int'(a_rgb), int'(e.rgb));
                    checkOutput("a_hsync", int'(a_hs), int'(e.hsync));
                    checkOutput("a_vsync", int'(a_vs), int'(e.vsync));
                    checkOutput("a_active", int'(a_act), int'(e.act));
                end else begin
                    checks_total++;
                    $display("[TB] FAIL a_queue_empty (cycle %0d): actual 0 entries, required 1", cyc);
                end
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    checkOutput("b_rgb", int'(b_rgb), int'(e.rgb));
                    checkOutput("b_hsync", int'(b_hs), int'(e.hsync));
                    checkOutput("b_vsync", int'(b_vs), int'(e.vsync));
                    checkOutput("b_active", int'(b_act), int'(e.act));
                end else begin
                    checks_total++;
                    $display("[TB] FAIL b_queue_empty (cycle %0d): actual 0 entries, required 1", cyc);
                end
                if (q_c.size() > 0) begin
                    e = q_c.pop_front();
                    checkOutput("c_rgb", int'(c_rgb), int'(e.rgb));
                    checkOutput("c_hsync", int'(c_hs), int'(e.hsync));
                    checkOutput("c_vsync", int'(c_vs), int'(e.vsync));
                    checkOutput("c_active", int'(c_act), int'(e.act));
                end else begin
                    checks_total++;
                    $display("[TB] FAIL c_queue_empty (cycle %0d): actual 0 entries, required 1", cyc);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        colour_a = 1'b1;
        colour_b = 1'b0;
        colour_c = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkResetState("por");

        releaseReset();
        applyStimulus(1);
        checkOutput("first_frame_start", int'(a_fs), 1);

        applyStimulus(900);
        checkOutput("hsync_offset", a_hs_first, 658);
        checkOutput("hsync_width", a_hs_len, 96);
        checkOutput("vsync_offset", c_vs_first, 107);
        checkOutput("vsync_width", c_vs_len, 30);

        // Last pixel of the 256th small frame, then the wrap to frame 0
        applyStimulus(37499);
        checkOutput("fcount_before_wrap", int'(c_fc), 255);
        applyStimulus(1);
        checkOutput("fcount_after_wrap", int'(c_fc), 0);
        checkOutput("fstart_at_wrap", int'(c_fs), 1);

        // Next cycle presents (300,49) on the full-timing instances
        applyStimulus(1099);
        @(posedge clk);
        #2;
        running = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkResetState("midframe");
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkResetState("held");

        releaseReset();
        applyStimulus(900);
        checkOutput("refill_hsync_offset", a_hs_first, 658);
        checkOutput("refill_hsync_width", a_hs_len, 96);

        running = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
